// File: rtl/elevator_scheduler.sv
// Four-floor SCAN elevator scheduler: latches calls, tracks the floor from
// one-hot sensors and sequences hoist motor and door with registered outputs.
module elevator_scheduler #(
    parameter int DOOR_CYCLES  = 8,
    parameter int MOVE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] call_req,
    input  logic [3:0] s,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [1:0] cur_floor,
    output logic [3:0] pending,
    output logic       dir_up,
    output logic       fault
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UP   = 3'd1;
    localparam logic [2:0] ST_DOWN = 3'd2;
    localparam logic [2:0] ST_DOOR = 3'd3;
    localparam logic [2:0] ST_FLT  = 3'd4;

    localparam int DW = $clog2(DOOR_CYCLES);
    localparam int TW = $clog2(MOVE_TIMEOUT);
    localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(MOVE_TIMEOUT - 1);

    logic [2:0]    state_r, state_nxt_s;
    logic [1:0]    cur_floor_r;
    logic [3:0]    pending_r;
    logic          dir_up_r, dir_up_nxt_s;
    logic [DW-1:0] door_cnt_r, door_cnt_nxt_s;
    logic [TW-1:0] to_cnt_r, to_cnt_nxt_s;
    logic          motor_up_r, motor_down_r, door_open_r, fault_r;
    logic          s_valid_s;
    logic [1:0]    s_floor_s;
    logic [3:0]    req_all_s, clear_s;
    logic          above_s, below_s, ahead_s;

    function automatic logic [3:0] floor_bit(input logic [1:0] f);
        return 4'b0001 << f;
    endfunction

    function automatic logic any_beyond(input logic [3:0] mask, input logic [1:0] f,
                                        input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = r | (mask[i] & (up ? (i > int'(f)) : (i < int'(f))));
        end
        return r;
    endfunction

    // Sensor decode: only a single high bit names a floor.
    always_comb begin
        s_valid_s = 1'b1;
        s_floor_s = 2'd0;
        case (s)
            4'b0001: s_floor_s = 2'd0;
            4'b0010: s_floor_s = 2'd1;
            4'b0100: s_floor_s = 2'd2;
            4'b1000: s_floor_s = 2'd3;
            default: s_valid_s = 1'b0;
        endcase
    end

    assign req_all_s = pending_r | call_req;
    assign above_s   = any_beyond(pending_r, cur_floor_r, 1'b1);
    assign below_s   = any_beyond(pending_r, cur_floor_r, 1'b0);
    assign ahead_s   = any_beyond(req_all_s, s_floor_s, state_r == ST_UP);

    // Next-state, counters and the per-edge pending clear mask.
    always_comb begin
        state_nxt_s    = state_r;
        door_cnt_nxt_s = door_cnt_r;
        to_cnt_nxt_s   = to_cnt_r;
        dir_up_nxt_s   = dir_up_r;
        clear_s        = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                to_cnt_nxt_s = {TW{1'b0}};
                if (pending_r[cur_floor_r]) begin
                    state_nxt_s    = ST_DOOR;
                    door_cnt_nxt_s = DOOR_LOAD;
                    clear_s        = floor_bit(cur_floor_r);
                end else if (above_s && below_s) begin
                    state_nxt_s = dir_up_r ? ST_UP : ST_DOWN;
                end else if (above_s) begin
                    state_nxt_s  = ST_UP;
                    dir_up_nxt_s = 1'b1;
                end else if (below_s) begin
                    state_nxt_s  = ST_DOWN;
                    dir_up_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UP, ST_DOWN: begin
                if (s_valid_s && req_all_s[s_floor_s]) begin
                    state_nxt_s    = ST_DOOR;
                    door_cnt_nxt_s = DOOR_LOAD;
                    clear_s        = floor_bit(s_floor_s);
                end else if (s_valid_s && !ahead_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (s_valid_s && (s_floor_s != cur_floor_r)) begin
                    to_cnt_nxt_s = {TW{1'b0}};
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = ST_FLT;
                end else begin
                    to_cnt_nxt_s = to_cnt_r + TW'(1);
                end
            end
            ST_DOOR: begin
                clear_s = floor_bit(cur_floor_r);
                if (call_req[cur_floor_r]) begin
                    door_cnt_nxt_s = DOOR_LOAD;
                end else if (door_cnt_r == {DW{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    door_cnt_nxt_s = door_cnt_r - DW'(1);
                end
            end
            ST_FLT: begin
                state_nxt_s = ST_FLT;
            end
            default: begin
                state_nxt_s = ST_FLT;
            end
        endcase
    end

    // State, datapath and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cur_floor_r  <= 2'd0;
            pending_r    <= 4'b0000;
            dir_up_r     <= 1'b1;
            door_cnt_r   <= {DW{1'b0}};
            to_cnt_r     <= {TW{1'b0}};
            motor_up_r   <= 1'b0;
            motor_down_r <= 1'b0;
            door_open_r  <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pending_r    <= req_all_s & ~clear_s;
            dir_up_r     <= dir_up_nxt_s;
            door_cnt_r   <= door_cnt_nxt_s;
            to_cnt_r     <= to_cnt_nxt_s;
            if (s_valid_s) begin
                cur_floor_r <= s_floor_s;
            end
            motor_up_r   <= (state_nxt_s == ST_UP);
            motor_down_r <= (state_nxt_s == ST_DOWN);
            door_open_r  <= (state_nxt_s == ST_DOOR);
            fault_r      <= (state_nxt_s == ST_FLT);
        end
    end

    assign motor_up   = motor_up_r;
    assign motor_down = motor_down_r;
    assign door_open  = door_open_r;
    assign cur_floor  = cur_floor_r;
    assign pending    = pending_r;
    assign dir_up     = dir_up_r;
    assign fault      = fault_r;
endmodule
